dispatch_queue: RTL and testbench

- In-order instruction buffer plus N-wide dispatcher; sits between decoder and the reservation stations (RS) / ROB.
- Accepts up to IN_W decoded instructions per cycle into a circular queue.
- Each cycle, dispatches up to DISP_W oldest entries to their target RS, limited by per-RS and ROB credits.
- Replaces the single-entry register with a parametrised buffer and adds flush handling.

---
 rtl/dispatch_pkg.sv | 19 +
 rtl/dispatch_select.sv | 40 ++++
 rtl/dispatch_queue.sv | 155 +++++++++++++++
 tb/tb_dispatch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared constants and types for the dispatch queue: FU-to-RS mapping and slot layout.
package dispatch_pkg;

  localparam int NUM_RS_DEF = 4;
  localparam int INST_W_DEF = 128;
  localparam int FU_IDX_W   = $clog2(NUM_RS_DEF);

  localparam logic [FU_IDX_W-1:0] FU_LSU  = FU_IDX_W'(0);
  localparam logic [FU_IDX_W-1:0] FU_MULT = FU_IDX_W'(1);
  localparam logic [FU_IDX_W-1:0] FU_BTU  = FU_IDX_W'(2);
  localparam logic [FU_IDX_W-1:0] FU_ALU  = FU_IDX_W'(3);

  typedef struct packed {
    logic                  valid;
    logic [INST_W_DEF-1:0] inst;
    logic [NUM_RS_DEF-1:0] rs_sel;
  } dispatch_slot_t;

endpackage

// File: rtl/dispatch_select.sv
// Combinational slot qualification: in-order prefix limited by occupancy, ROB credit
// and a running per-RS credit count.
module dispatch_select #(
  parameter int DISP_W = 2,
  parameter int NUM_RS = 4,
  parameter int CRED_W = 4,
  parameter int CNT_W  = 4,
  parameter int FU_W   = $clog2(NUM_RS)
) (
  input  logic                           en,
  input  logic [CNT_W-1:0]               count,
  input  logic [DISP_W-1:0][FU_W-1:0]    slot_fu,
  input  logic [NUM_RS-1:0][CRED_W-1:0]  rs_free_cnt,
  input  logic [CRED_W-1:0]              rob_free_cnt,
  output logic [DISP_W-1:0]              slot_valid,
  output logic [DISP_W-1:0][NUM_RS-1:0]  slot_rs_sel
);

  int   used_cnt [NUM_RS];
  logic chain_open;

  always_comb begin
    slot_valid  = '0;
    slot_rs_sel = '0;
    chain_open  = en;
    for (int r = 0; r < NUM_RS; r++) used_cnt[r] = 0;
    for (int k = 0; k < DISP_W; k++) begin
      // Once a slot is blocked every younger slot stays blocked to keep dispatch in order.
      if (chain_open && (int'(count) > k) && (int'(rob_free_cnt) > k) &&
          (used_cnt[slot_fu[k]] < int'(rs_free_cnt[slot_fu[k]]))) begin
        slot_valid[k]              = 1'b1;
        slot_rs_sel[k][slot_fu[k]] = 1'b1;
        used_cnt[slot_fu[k]]       = used_cnt[slot_fu[k]] + 1;
      end else begin
        chain_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction buffer with credit-limited N-wide dispatch and flush.
// Optional statistics counters are enabled with DISPATCH_QUEUE_STATS_EN.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int IN_W   = 2,
  parameter int DISP_W = 2,
  parameter int NUM_RS = NUM_RS_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int CRED_W = 4,
  localparam int FU_W  = $clog2(NUM_RS),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [IN_W-1:0]                enq_valid,
  input  logic [IN_W-1:0][INST_W-1:0]    enq_inst,
  input  logic [IN_W-1:0][FU_W-1:0]      enq_fu,
  output logic                           enq_ready,
  input  logic [NUM_RS-1:0][CRED_W-1:0]  rs_free_cnt,
  input  logic [CRED_W-1:0]              rob_free_cnt,
  output logic [DISP_W-1:0]              disp_valid,
  output logic [DISP_W-1:0][INST_W-1:0]  disp_inst,
  output logic [DISP_W-1:0][NUM_RS-1:0]  disp_rs_sel,
  output logic [CNT_W-1:0]               count,
  output logic                           stall
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                    stat_stall_cycles,
  output logic [31:0]                    stat_full_cycles,
  output logic [31:0]                    stat_dispatched
`endif
);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] mem_d [DEPTH];
  logic [FU_W-1:0]   fu_q  [DEPTH];
  logic [FU_W-1:0]   fu_d  [DEPTH];

  logic [DISP_W-1:0][FU_W-1:0] slot_fu;
  logic [CNT_W-1:0]            enq_n, disp_n;
  logic                        enq_fire;

  always_comb begin
    for (int k = 0; k < DISP_W; k++) slot_fu[k] = fu_q[head_q + PTR_W'(k)];
  end

  dispatch_select #(
    .DISP_W (DISP_W),
    .NUM_RS (NUM_RS),
    .CRED_W (CRED_W),
    .CNT_W  (CNT_W),
    .FU_W   (FU_W)
  ) u_select (
    .en           (!(flush || reset)),
    .count        (count_q),
    .slot_fu      (slot_fu),
    .rs_free_cnt  (rs_free_cnt),
    .rob_free_cnt (rob_free_cnt),
    .slot_valid   (disp_valid),
    .slot_rs_sel  (disp_rs_sel)
  );

  // Readiness looks only at current occupancy; same-cycle dispatches are not credited.
  assign enq_ready = (count_q <= CNT_W'(DEPTH - IN_W));
  assign enq_fire  = (|enq_valid) && enq_ready && !flush && !reset;

  always_comb begin
    enq_n  = '0;
    disp_n = '0;
    for (int i = 0; i < IN_W; i++)   enq_n  = enq_n  + CNT_W'(enq_valid[i]);
    for (int k = 0; k < DISP_W; k++) disp_n = disp_n + CNT_W'(disp_valid[k]);
  end

  always_comb begin
    mem_d   = mem_q;
    fu_d    = fu_q;
    head_d  = head_q + PTR_W'(disp_n);
    tail_d  = tail_q;
    count_d = count_q - disp_n;
    if (enq_fire) begin
      for (int i = 0; i < IN_W; i++) begin
        if (enq_valid[i]) begin
          mem_d[tail_q + PTR_W'(i)] = enq_inst[i];
          fu_d[tail_q + PTR_W'(i)]  = enq_fu[i];
        end
      end
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - disp_n;
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
    fu_q  <= fu_d;
  end

  always_comb begin
    for (int k = 0; k < DISP_W; k++)
      disp_inst[k] = disp_valid[k] ? mem_q[head_q + PTR_W'(k)] : '0;
  end

  assign count = count_q;
  assign stall = (count_q != '0) && !disp_valid[0];

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0] stall_cyc_q, stall_cyc_d, full_cyc_q, full_cyc_d, disp_tot_q, disp_tot_d;
  logic [32:0] disp_sum;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    full_cyc_d  = full_cyc_q;
    if (stall && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 32'd1;
    if ((count_q == CNT_W'(DEPTH)) && (full_cyc_q != '1)) full_cyc_d = full_cyc_q + 32'd1;
    disp_sum   = {1'b0, disp_tot_q} + 33'(disp_n);
    disp_tot_d = disp_sum[32] ? '1 : disp_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q <= '0;
      full_cyc_q  <= '0;
      disp_tot_q  <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      full_cyc_q  <= full_cyc_d;
      disp_tot_q  <= disp_tot_d;
    end
  end

  assign stat_stall_cycles = stall_cyc_q;
  assign stat_full_cycles  = full_cyc_q;
  assign stat_dispatched   = disp_tot_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_dispatch_queue;
  import dispatch_pkg::*;

  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    reset, flush;
  logic [1:0]              enq_valid;
  logic [1:0][127:0]       enq_inst;
  logic [1:0][FU_IDX_W-1:0] enq_fu;
  logic                    enq_ready;
  logic [3:0][3:0]         rs_free_cnt;
  logic [3:0]              rob_free_cnt;
  logic [1:0]              disp_valid;
  logic [1:0][127:0]       disp_inst;
  logic [1:0][3:0]         disp_rs_sel;
  logic [3:0]              count;
  logic                    stall;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [127:0] inst; int fu; } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  dispatch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_inst     (enq_inst),
    .enq_fu       (enq_fu),
    .enq_ready    (enq_ready),
    .rs_free_cnt  (rs_free_cnt),
    .rob_free_cnt (rob_free_cnt),
    .disp_valid   (disp_valid),
    .disp_inst    (disp_inst),
    .disp_rs_sel  (disp_rs_sel),
    .count        (count),
    .stall        (stall)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_inst();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_enq(input int n, input int fu0, input int fu1);
    enq_valid = 2'((1 << n) - 1);
    enq_inst[0] = rand_inst();
    enq_inst[1] = rand_inst();
    enq_fu[0] = FU_IDX_W'(fu0);
    enq_fu[1] = FU_IDX_W'(fu1);
  endtask

  task automatic set_credits(input int rs, input int rob);
    for (int r = 0; r < 4; r++) rs_free_cnt[r] = 4'(rs);
    rob_free_cnt = 4'(rob);
  endtask

  // One clock: compare all outputs against the model at negedge, then advance the model.
  task automatic cycle();
    logic [1:0]        ev;
    logic [1:0][3:0]   es;
    logic [1:0][127:0] ei;
    int  used [4];
    int  nd;
    bit  open, rdy;
    @(negedge clk);
    ev = '0; es = '0; ei = '0; nd = 0;
    for (int r = 0; r < 4; r++) used[r] = 0;
    open = !(reset || flush);
    for (int k = 0; k < 2; k++) begin
      if (open && k < mq.size() && k < int'(rob_free_cnt) &&
          used[mq[k].fu] < int'(rs_free_cnt[mq[k].fu])) begin
        ev[k] = 1'b1;
        es[k][mq[k].fu] = 1'b1;
        ei[k] = mq[k].inst;
        used[mq[k].fu]++;
        nd++;
      end else open = 0;
    end
    rdy = (mq.size() <= DEPTH - 2);
    check_eq("enq_ready", 256'(enq_ready), 256'(rdy));
    check_eq("disp_valid", 256'(disp_valid), 256'(ev));
    check_eq("disp_rs_sel", 256'(disp_rs_sel), 256'(es));
    check_eq("disp_inst", 256'(disp_inst), 256'(ei));
    check_eq("count", 256'(count), 256'(mq.size()));
    check_eq("stall", 256'(stall), 256'(mq.size() > 0 && !ev[0]));
    @(posedge clk);
    if (reset || flush) mq.delete();
    else begin
      repeat (nd) void'(mq.pop_front());
      if (rdy && enq_valid != 0)
        for (int i = 0; i < 2; i++)
          if (enq_valid[i]) mq.push_back('{inst: enq_inst[i], fu: int'(enq_fu[i])});
    end
    #1;
  endtask

  task automatic rand_inputs();
    reset = ($urandom_range(0, 79) == 0);
    flush = ($urandom_range(0, 39) == 0);
    set_enq($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
    for (int r = 0; r < 4; r++) rs_free_cnt[r] = 4'($urandom_range(0, 3));
    rob_free_cnt = 4'($urandom_range(0, 4));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_enq(0, 0, 0);
    set_credits(0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("rst_count", 256'(count), 256'(0));
    check_eq("rst_enq_ready", 256'(enq_ready), 256'(1));
    check_eq("rst_disp_valid", 256'(disp_valid), 256'(0));
    check_eq("rst_stall", 256'(stall), 256'(0));
    cycle();

    // Two ALU ops with a single ALU credit drain one per cycle.
    set_credits(0, 8);
    rs_free_cnt[3] = 4'd1;
    set_enq(2, FU_ALU, FU_ALU);
    cycle();
    set_enq(0, 0, 0);
    #1;
    check_eq("alu_disp_valid", 256'(disp_valid), 256'(2'b01));
    check_eq("alu_rs_sel0", 256'(disp_rs_sel[0]), 256'(4'b1000));
    check_eq("alu_count2", 256'(count), 256'(2));
    check_eq("alu_stall", 256'(stall), 256'(0));
    cycle();
    check_eq("alu_count1", 256'(count), 256'(1));
    cycle();

    // Fill with zero credits, then drain across the pointer wrap.
    set_credits(0, 0);
    for (int g = 0; g < 4; g++) begin
      set_enq(2, $urandom_range(0, 3), $urandom_range(0, 3));
      cycle();
    end
    set_enq(0, 0, 0);
    #1;
    check_eq("full_count", 256'(count), 256'(8));
    check_eq("full_enq_ready", 256'(enq_ready), 256'(0));
    check_eq("full_stall", 256'(stall), 256'(1));
    set_credits(4, 4);
    repeat (4) cycle();
    check_eq("drained_count", 256'(count), 256'(0));

    // Blocked MULT at head must hold the ALU behind it.
    set_credits(4, 4);
    rs_free_cnt[1] = 4'd0;
    set_enq(2, FU_MULT, FU_ALU);
    cycle();
    set_enq(0, 0, 0);
    #1;
    check_eq("inorder_disp_valid", 256'(disp_valid), 256'(2'b00));
    cycle();
    set_credits(4, 1);
    #1;
    check_eq("rob1_disp_valid", 256'(disp_valid), 256'(2'b01));
    cycle();
    set_credits(4, 4);
    cycle();

    // Flush with count 5 and a simultaneous enqueue.
    set_credits(0, 0);
    set_enq(2, 0, 1); cycle();
    set_enq(2, 2, 3); cycle();
    set_enq(1, 3, 0); cycle();
    check_eq("preflush_count", 256'(count), 256'(5));
    set_credits(4, 4);
    flush = 1'b1;
    set_enq(2, 1, 2);
    #1;
    check_eq("flush_disp_valid", 256'(disp_valid), 256'(2'b00));
    cycle();
    flush = 1'b0;
    set_enq(0, 0, 0);
    #1;
    check_eq("postflush_count", 256'(count), 256'(0));

    // Reset in the middle of a drain.
    set_credits(0, 0);
    set_enq(2, 3, 2); cycle();
    set_enq(2, 1, 0); cycle();
    set_enq(0, 0, 0);
    set_credits(4, 4);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check_eq("postrst_count", 256'(count), 256'(0));
    check_eq("postrst_enq_ready", 256'(enq_ready), 256'(1));

    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
